// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register indices, instruction codes and the
// write-back scheduler state encoding.
package y86_pkg;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } wb_state_t;

endpackage

// File: rtl/rfw_hazard_cmp.sv
// Flags a decode source that matches one of up to two pending write-back
// destinations; a source of all-ones (no register) never matches.
module rfw_hazard_cmp #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic [REG_W-1:0] pend0_i,
  input  logic [REG_W-1:0] pend1_i,
  output logic             hazard_o
);

  localparam logic [REG_W-1:0] NOREG = '1;

  logic hit_a;
  logic hit_b;

  always_comb begin
    hit_a    = (src_a_i != NOREG) && ((src_a_i == pend0_i) || (src_a_i == pend1_i));
    hit_b    = (src_b_i != NOREG) && ((src_b_i == pend0_i) || (src_b_i == pend1_i));
    hazard_o = hit_a || hit_b;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Serializes Y86-64 write-back bundles onto the register file's single write
// port. Define RFW_HAZARD_CHECK_EN to add the src_a/src_b/hazard compare ports.
module regfile_wb_scheduler
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_dstE,
  input  logic [DATA_W-1:0] in_valE,
  input  logic [REG_W-1:0]  in_dstM,
  input  logic [DATA_W-1:0] in_valM,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
`ifdef RFW_HAZARD_CHECK_EN
  input  logic [REG_W-1:0]  src_a,
  input  logic [REG_W-1:0]  src_b,
  output logic              hazard,
`endif
  output logic              busy
);

  localparam logic [REG_W-1:0] NOREG = '1;

  wb_state_t         state_q, state_d;
  logic [REG_W-1:0]  dstE_q, dstE_d;
  logic [REG_W-1:0]  dstM_q, dstM_d;
  logic [DATA_W-1:0] valE_q, valE_d;
  logic [DATA_W-1:0] valM_q, valM_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic final_wr;
  logic accept;
  logic e_ok;
  logic m_ok;
  logic e_first;

  always_comb begin
    final_wr  = (state_q == WR_M) || ((state_q == WR_E) && (dstM_q == NOREG));
    in_ready  = (state_q == IDLE) || final_wr;
    accept    = in_valid && in_ready;
    e_ok      = (in_dstE != NOREG);
    m_ok      = (in_dstM != NOREG);
    // A same-destination bundle keeps only its M write, so dstE is dropped here.
    e_first   = e_ok && !(m_ok && (in_dstE == in_dstM));

    state_d   = IDLE;
    dstE_d    = dstE_q;
    dstM_d    = dstM_q;
    valE_d    = valE_q;
    valM_d    = valM_q;
    wr_addr_d = NOREG;
    wr_data_d = '0;

    if (accept) begin
      dstE_d = e_first ? in_dstE : NOREG;
      dstM_d = in_dstM;
      valE_d = in_valE;
      valM_d = in_valM;
      if (e_first) begin
        state_d   = WR_E;
        wr_addr_d = in_dstE;
        wr_data_d = in_valE;
      end else if (m_ok) begin
        state_d   = WR_M;
        wr_addr_d = in_dstM;
        wr_data_d = in_valM;
      end
    end else if ((state_q == WR_E) && (dstM_q != NOREG)) begin
      state_d   = WR_M;
      wr_addr_d = dstM_q;
      wr_data_d = valM_q;
    end

    wr_en_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dstE_q    <= NOREG;
      dstM_q    <= NOREG;
      valE_q    <= '0;
      valM_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= NOREG;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dstE_q    <= dstE_d;
      dstM_q    <= dstM_d;
      valE_q    <= valE_d;
      valM_q    <= valM_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != IDLE);

`ifdef RFW_HAZARD_CHECK_EN
  logic [REG_W-1:0] pend0;
  logic [REG_W-1:0] pend1;

  // In WR_E the latched dstM is the queued write; in WR_M it is the current one.
  always_comb begin
    pend0 = (state_q == WR_E) ? dstE_q : NOREG;
    pend1 = (state_q != IDLE) ? dstM_q : NOREG;
  end

  rfw_hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
    .src_a_i  (src_a),
    .src_b_i  (src_b),
    .pend0_i  (pend0),
    .pend1_i  (pend1),
    .hazard_o (hazard)
  );
`endif

endmodule
